// File: rtl/dat_mem_dma_pkg.sv
// +--------------------------------------------------------------------+
// | dma_pkg : shared types and widths for the dat_mem_dma copy engine  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package dma_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_t;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } dma_op_t;

endpackage

`default_nettype wire

// File: rtl/dat_mem_dma_if.sv
// +--------------------------------------------------------------------+
// | dat_mem_dma_if : control, CPU-side and memory-side bus of the DMA  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface dat_mem_dma_if;
  import dma_pkg::*;

  logic              start;
  logic              op;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] fill_val;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dat_in;
  logic              cpu_wr_en;
  logic [DATA_W-1:0] cpu_dat_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dat_in;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_dat_out;
  logic              busy;
  logic              done;

  // slave = the DMA engine, master = CPU plus memory environment
  modport slave (
    input  start, op, src, dst, len, fill_val,
    input  cpu_addr, cpu_dat_in, cpu_wr_en, mem_dat_out,
    output cpu_dat_out, mem_addr, mem_dat_in, mem_wr_en, busy, done
  );

  modport master (
    output start, op, src, dst, len, fill_val,
    output cpu_addr, cpu_dat_in, cpu_wr_en, mem_dat_out,
    input  cpu_dat_out, mem_addr, mem_dat_in, mem_wr_en, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/dat_mem_dma_mem_port_mux.sv
// +--------------------------------------------------------------------+
// | mem_port_mux : selects CPU or engine request onto the memory port  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_port_mux
  import dma_pkg::*;
(
  input  logic              reset_i,
  input  logic              busy_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_dat_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] eng_addr_i,
  input  logic [DATA_W-1:0] eng_dat_i,
  input  logic              eng_we_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_dat_o,
  output logic              mem_we_o
);

  always_comb begin
    mem_addr_o = busy_i ? eng_addr_i : cpu_addr_i;
    mem_dat_o  = busy_i ? eng_dat_i  : cpu_dat_i;
    // No write may land in a reset cycle, whoever owns the port.
    mem_we_o   = reset_i ? 1'b0 : (busy_i ? eng_we_i : cpu_we_i);
  end

endmodule

`default_nettype wire

// File: rtl/dat_mem_dma.sv
// +--------------------------------------------------------------------+
// | dat_mem_dma : byte copy / fill engine in front of the 256x8 memory |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dat_mem_dma
  import dma_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  dat_mem_dma_if.slave  bus
);

  dma_state_t        state_q;
  dma_op_t           op_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] buf_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] idx_d;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_dat;
  logic              eng_we;

  assign idx_d = idx_q + 8'd1;

  // Address sums wrap naturally at 8 bits.
  always_comb begin
    eng_addr = '0;
    eng_dat  = '0;
    eng_we   = 1'b0;
    unique case (state_q)
      RD: eng_addr = src_q + idx_q;
      WR: begin
        eng_addr = dst_q + idx_q;
        eng_dat  = (op_q == FILL) ? fill_q : buf_q;
        eng_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= COPY;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q   <= dma_op_t'(bus.op);
            src_q  <= bus.src;
            dst_q  <= bus.dst;
            len_q  <= bus.len;
            fill_q <= bus.fill_val;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (bus.len == 8'd0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else if (dma_op_t'(bus.op) == COPY) begin
              state_q <= RD;
            end else begin
              state_q <= WR;
            end
          end
        end
        RD: begin
          buf_q   <= bus.mem_dat_out;
          state_q <= WR;
        end
        WR: begin
          idx_q <= idx_d;
          if (idx_d == len_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (op_q == COPY) begin
            state_q <= RD;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_port_mux u_mux (
    .reset_i    (reset),
    .busy_i     (busy_q),
    .cpu_addr_i (bus.cpu_addr),
    .cpu_dat_i  (bus.cpu_dat_in),
    .cpu_we_i   (bus.cpu_wr_en),
    .eng_addr_i (eng_addr),
    .eng_dat_i  (eng_dat),
    .eng_we_i   (eng_we),
    .mem_addr_o (bus.mem_addr),
    .mem_dat_o  (bus.mem_dat_in),
    .mem_we_o   (bus.mem_wr_en)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cpu_dat_out = bus.mem_dat_out;

endmodule

`default_nettype wire

// File: tb/tb_dat_mem_dma.sv
// +--------------------------------------------------------------------+
// | tb_dat_mem_dma : bench for dat_mem_dma with a 256x8 memory model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dat_mem_dma;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dat_mem_dma_if bus ();

  dat_mem_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // The data memory the engine sits in front of: combinational read, clocked write.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  assign bus.mem_dat_out = mem[bus.mem_addr];
  always_ff @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_dat_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       op;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill;
    int         lat;
    logic [7:0] pa;
    logic [7:0] pv;
    logic [7:0] qa;
    logic [7:0] qv;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_mem(input string nm);
    int bad;
    bad = -1;
    for (int a = 0; a < 256; a++)
      if (bad < 0 && mem[a] !== ref_mem[a]) bad = a;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: mem[0x%0h] got 0x%0h expected 0x%0h", nm, bad, mem[bad], ref_mem[bad]);
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_addr   = a;
    bus.cpu_dat_in = d;
    bus.cpu_wr_en  = 1'b1;
    @(negedge clk);
    bus.cpu_wr_en  = 1'b0;
    ref_mem[a]     = d;
  endtask

  task automatic cpu_read(input logic [7:0] a, input string nm);
    bus.cpu_addr = a;
    #1;
    check(nm, int'(bus.cpu_dat_out), int'(ref_mem[a]));
  endtask

  task automatic run_op(input logic op_v, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] l, input logic [7:0] f, input int exp_lat,
                        input string nm);
    int lat, wrc, busyc;
    bit seen;
    logic [7:0] ai;
    bus.start    = 1'b1;
    bus.op       = op_v;
    bus.src      = s;
    bus.dst      = d;
    bus.len      = l;
    bus.fill_val = f;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; wrc = 0; busyc = 0; seen = 1'b0;
    for (int k = 1; k <= 600 && !seen; k++) begin
      @(negedge clk);
      if (bus.busy) busyc++;
      if (bus.mem_wr_en) wrc++;
      if (bus.done) begin
        seen          = 1'b1;
        lat           = k;
        bus.start     = 1'b0;
        bus.cpu_wr_en = 1'b0;
      end else begin
        // Restarts and CPU writes while busy must all be ignored.
        bus.start      = 1'($urandom_range(0, 1));
        bus.op         = 1'($urandom_range(0, 1));
        bus.src        = 8'($urandom);
        bus.dst        = 8'($urandom);
        bus.len        = 8'($urandom);
        bus.fill_val   = 8'($urandom);
        bus.cpu_addr   = 8'($urandom);
        bus.cpu_dat_in = 8'($urandom);
        bus.cpu_wr_en  = 1'($urandom_range(0, 1));
      end
    end
    check({nm, "_done_seen"}, int'(seen), 1);
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_writes"}, wrc, int'(l));
    check({nm, "_busy_cycles"}, busyc, exp_lat);
    @(negedge clk);
    check({nm, "_busy_after"}, int'(bus.busy), 0);
    check({nm, "_done_after"}, int'(bus.done), 0);
    for (int k = 0; k < int'(l); k++) begin
      ai = d + 8'(k);
      ref_mem[ai] = op_v ? f : ref_mem[8'(s + 8'(k))];
    end
    check_mem({nm, "_mem"});
  endtask

  initial begin
    int nd, lr, lat_e;
    logic op_r;
    logic [7:0] s_r, d_r;

    tbl[0] = '{1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 5, 8'h13, 8'hA5, 8'h14, 8'h15};
    tbl[1] = '{1'b0, 8'h00, 8'h80, 8'd3, 8'h00, 7, 8'h82, 8'h03, 8'h83, 8'h84};
    tbl[2] = '{1'b0, 8'hFE, 8'hFF, 8'd2, 8'h00, 5, 8'h00, 8'h07, 8'hFF, 8'h07};
    tbl[3] = '{1'b1, 8'h00, 8'h40, 8'd0, 8'h5C, 1, 8'h40, 8'h41, 8'h41, 8'h42};
    tbl[4] = '{1'b1, 8'h00, 8'hFE, 8'd3, 8'h3C, 4, 8'h00, 8'h3C, 8'h01, 8'h02};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    bus.fill_val = '0; bus.cpu_addr = 8'h33; bus.cpu_dat_in = 8'h99; bus.cpu_wr_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_wr_gate", int'(bus.mem_wr_en), 0);
    check("rst_addr_pass", int'(bus.mem_addr), 'h33);
    reset = 1'b0;
    bus.cpu_wr_en = 1'b0;
    @(negedge clk);

    for (int a = 0; a < 256; a++) cpu_write(8'(a), 8'(a + 1));
    cpu_write(8'hFE, 8'h07);
    cpu_write(8'hFF, 8'h09);
    check_mem("init_mem");
    cpu_read(8'h05, "cpu_read_05");
    cpu_read(8'hFE, "cpu_read_fe");

    // Reset while idle with a CPU write pending must not write.
    reset = 1'b1;
    bus.cpu_addr = 8'h20; bus.cpu_dat_in = 8'h00; bus.cpu_wr_en = 1'b1;
    #1 check("idle_rst_wr_gate", int'(bus.mem_wr_en), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_wr_en = 1'b0;
    check("idle_rst_mem20", int'(mem[8'h20]), 'h21);

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].fill, tbl[i].lat,
             $sformatf("vec%0d", i));
      check($sformatf("vec%0d_probe_a", i), int'(mem[tbl[i].pa]), int'(tbl[i].pv));
      check($sformatf("vec%0d_probe_b", i), int'(mem[tbl[i].qa]), int'(tbl[i].qv));
    end

    // Reset in the fourth WR cycle of an 8-byte fill.
    bus.start = 1'b1; bus.op = 1'b1; bus.dst = 8'h60; bus.len = 8'd8; bus.fill_val = 8'hEE;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_wr_before", int'(bus.mem_wr_en), 1);
    reset = 1'b1;
    #1 check("abort_wr_gated", int'(bus.mem_wr_en), 0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    check("abort_no_done", nd, 0);
    for (int k = 0; k < 3; k++) ref_mem[8'h60 + k] = 8'hEE;
    check_mem("abort_mem");
    cpu_write(8'h63, 8'h77);
    cpu_read(8'h63, "abort_cpu_write");

    for (int r = 0; r < 25; r++) begin
      op_r = 1'($urandom_range(0, 1));
      s_r  = 8'($urandom);
      d_r  = 8'($urandom);
      lr   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 255))
                                         : int'($urandom_range(0, 24));
      lat_e = (lr == 0) ? 1 : (op_r ? lr + 1 : 2 * lr + 1);
      run_op(op_r, s_r, d_r, 8'(lr), 8'($urandom), lat_e, $sformatf("rnd%0d", r));
      cpu_write(8'($urandom), 8'($urandom));
      cpu_read(8'($urandom), $sformatf("rnd%0d_cpu_read", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
